// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller for the in-order pipeline.
// Tracks in-flight destination registers through DEPTH post-decode stages
// (1=E ... DEPTH=W), stalls D on results that are not ready yet, and
// registers per-operand forwarding selects that line up with the
// instruction once it reaches E.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_we,
    input  logic                  id_is_load,
    input  logic                  flush,
    input  logic                  hold,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_e,
    output logic [SEL_W-1:0]      fwd_a_sel,
    output logic [SEL_W-1:0]      fwd_b_sel,
    output logic [CNT_W-1:0]      stall_cnt
);

    // A load result only becomes usable at the end of its ready stage, and a
    // producer in the last stage must already be in the register file.
    if ((LOAD_READY < 1) || (LOAD_READY > DEPTH - 1)) begin : g_cfg_check
        $error("hazard_scoreboard: LOAD_READY must lie in 1..DEPTH-1");
    end

    // Forwarding select for a matched producer stage. The last stage has
    // already written the register file on the negedge, so it maps to 0.
    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] m);
        logic [SEL_W-1:0] r;
        if ((m != '0) && (m < SEL_W'(DEPTH))) begin
            r = m + SEL_W'(1);
        end else begin
            r = '0;
        end
        return r;
    endfunction

    logic [DEPTH:1]        valid_r;
    logic [DEPTH:1]        we_r;
    logic [DEPTH:1]        load_r;
    logic [REG_ADDR_W-1:0] dst_r [1:DEPTH];

    logic [SEL_W-1:0] match_a_s;
    logic [SEL_W-1:0] match_b_s;
    logic [SEL_W-1:0] rdy_a_s;
    logic [SEL_W-1:0] rdy_b_s;
    logic             haz_s;
    logic             insert_s;

    // Youngest matching producer per source; scanning oldest-first lets the
    // lowest stage index overwrite older matches.
    always_comb begin
        match_a_s = '0;
        match_b_s = '0;
        rdy_a_s   = SEL_W'(1);
        rdy_b_s   = SEL_W'(1);
        for (int s = DEPTH; s >= 1; s--) begin
            if (id_use_rs && (id_rs != '0) && valid_r[s] && we_r[s] && (dst_r[s] == id_rs)) begin
                match_a_s = SEL_W'(s);
                rdy_a_s   = load_r[s] ? SEL_W'(LOAD_READY) : SEL_W'(1);
            end else begin
                match_a_s = match_a_s;
            end
            if (id_use_rt && (id_rt != '0) && valid_r[s] && we_r[s] && (dst_r[s] == id_rt)) begin
                match_b_s = SEL_W'(s);
                rdy_b_s   = load_r[s] ? SEL_W'(LOAD_READY) : SEL_W'(1);
            end else begin
                match_b_s = match_b_s;
            end
        end
    end

    // Stall when a used source comes from a stage whose result is not ready;
    // a flushed D instruction never stalls.
    always_comb begin
        haz_s    = id_valid && !flush &&
                   (((match_a_s != '0) && (match_a_s < rdy_a_s)) ||
                    ((match_b_s != '0) && (match_b_s < rdy_b_s)));
        insert_s = id_valid && !haz_s && !flush;
    end

    assign stall_f = haz_s;
    assign stall_d = haz_s;
    assign flush_e = (haz_s || flush) && !hold;

    // Advance the in-flight entry pipe; D enters stage 1 or a bubble does.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= '0;
            we_r    <= '0;
            load_r  <= '0;
            for (int s = 1; s <= DEPTH; s++) begin
                dst_r[s] <= '0;
            end
        end else if (!hold) begin
            for (int s = DEPTH; s >= 2; s--) begin
                valid_r[s] <= valid_r[s-1];
                we_r[s]    <= we_r[s-1];
                load_r[s]  <= load_r[s-1];
                dst_r[s]   <= dst_r[s-1];
            end
            valid_r[1] <= insert_s;
            we_r[1]    <= insert_s && id_we;
            load_r[1]  <= insert_s && id_is_load;
            dst_r[1]   <= id_dst;
        end
    end

    // Register forwarding selects so they accompany the instruction into E.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_a_sel <= '0;
            fwd_b_sel <= '0;
        end else if (!hold) begin
            fwd_a_sel <= insert_s ? next_sel(match_a_s) : '0;
            fwd_b_sel <= insert_s ? next_sel(match_b_s) : '0;
        end
    end

    // Saturating count of cycles spent stalled (frozen cycles excluded).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (haz_s && !hold && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (DEPTH=3, LOAD_READY=2) with a second
// instance using a 2-bit stall counter to exercise saturation.
module tb_hazard_scoreboard;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic [4:0] id_dst;
    logic       id_we;
    logic       id_is_load;
    logic       flush;
    logic       hold;

    logic        stall_f, stall_d, flush_e;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_cnt;

    logic        s_stall_f, s_stall_d, s_flush_e;
    logic [1:0]  s_fwd_a_sel, s_fwd_b_sel;
    logic [1:0]  s_stall_cnt;

    int n_pass;
    int n_total;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst), .id_we(id_we),
        .id_is_load(id_is_load), .flush(flush), .hold(hold),
        .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(.CNT_W(2)) sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst), .id_we(id_we),
        .id_is_load(id_is_load), .flush(flush), .hold(hold),
        .stall_f(s_stall_f), .stall_d(s_stall_d), .flush_e(s_flush_e),
        .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel), .stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] dst,
                         input logic we, input logic ld);
        id_valid   = v;
        id_rs      = rs;
        id_rt      = rt;
        id_use_rs  = urs;
        id_use_rt  = urt;
        id_dst     = dst;
        id_we      = we;
        id_is_load = ld;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (n) step();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b0;
        flush   = 1'b0;
        hold    = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        #2;
        chk("reset_stall_f", 32'(stall_f), 32'd0);
        chk("reset_stall_d", 32'(stall_d), 32'd0);
        chk("reset_flush_e", 32'(flush_e), 32'd0);
        chk("reset_fwd_a", 32'(fwd_a_sel), 32'd0);
        chk("reset_fwd_b", 32'(fwd_b_sel), 32'd0);
        chk("reset_cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // ALU forwarding from M and W
        step();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);       // add $3,$1,$2
        #1;
        chk("alu_prod_nostall", 32'(stall_f), 32'd0);
        step();
        drive(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);       // add $4,$3,$1
        #1;
        chk("alu_use_nostall", 32'(stall_f), 32'd0);
        step();
        chk("alu_fwd_m_a", 32'(fwd_a_sel), 32'd2);
        chk("alu_fwd_m_b", 32'(fwd_b_sel), 32'd0);
        drive(1'b1, 5'd3, 5'd9, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);       // add $8,$3,$9
        #1;
        chk("alu_gap_nostall", 32'(stall_f), 32'd0);
        step();
        chk("alu_fwd_w_a", 32'(fwd_a_sel), 32'd3);
        drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);      // $3 producer now in W
        step();
        chk("alu_fwd_regfile", 32'(fwd_a_sel), 32'd0);
        idle(3);

        // Load-use: one stall, then forward from W
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);       // lw $5
        step();
        drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);       // add $6,$5,$5
        #1;
        chk("lu_stall_f", 32'(stall_f), 32'd1);
        chk("lu_stall_d", 32'(stall_d), 32'd1);
        chk("lu_flush_e", 32'(flush_e), 32'd1);
        step();
        chk("lu_cnt", 32'(stall_cnt), 32'd1);
        chk("lu_bubble_sel", 32'(fwd_a_sel), 32'd0);
        #1;
        chk("lu_release", 32'(stall_f), 32'd0);
        step();
        chk("lu_fwd_a", 32'(fwd_a_sel), 32'd3);
        chk("lu_fwd_b", 32'(fwd_b_sel), 32'd3);
        chk("lu_cnt_hold", 32'(stall_cnt), 32'd1);
        idle(3);

        // Register zero is never a hazard
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);       // lw $0
        step();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0);
        #1;
        chk("zero_nostall", 32'(stall_f), 32'd0);
        step();
        chk("zero_sel", 32'(fwd_a_sel), 32'd0);
        idle(3);

        // Unused sources are ignored
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b1);      // lw $11
        step();
        drive(1'b1, 5'd11, 5'd11, 1'b0, 1'b0, 5'd13, 1'b1, 1'b0);
        #1;
        chk("nouse_nostall", 32'(stall_f), 32'd0);
        step();
        chk("nouse_sel_a", 32'(fwd_a_sel), 32'd0);
        chk("nouse_sel_b", 32'(fwd_b_sel), 32'd0);
        idle(3);

        // Two producers of $7: the younger one wins
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0);
        #1;
        chk("young_nostall", 32'(stall_f), 32'd0);
        step();
        chk("young_sel", 32'(fwd_a_sel), 32'd2);
        idle(3);

        // Flush during a load-use hazard
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);       // lw $5
        step();
        drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        chk("flush_stall_f", 32'(stall_f), 32'd0);
        chk("flush_flush_e", 32'(flush_e), 32'd1);
        step();
        flush = 1'b0;
        chk("flush_cnt", 32'(stall_cnt), 32'd1);
        #1;
        chk("flush_after_nostall", 32'(stall_f), 32'd0);
        step();
        chk("flush_after_sel", 32'(fwd_a_sel), 32'd3);
        idle(3);

        // Hold for three cycles in the middle of a load-use hazard
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0);       // add $2
        step();
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);       // lw $5,($2)
        step();
        chk("hold_pre_sel", 32'(fwd_a_sel), 32'd2);
        drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        hold = 1'b1;
        #1;
        chk("hold_stall_f", 32'(stall_f), 32'd1);
        chk("hold_flush_e", 32'(flush_e), 32'd0);
        repeat (3) begin
            step();
            chk("hold_cnt_frozen", 32'(stall_cnt), 32'd1);
            chk("hold_sel_frozen", 32'(fwd_a_sel), 32'd2);
        end
        hold = 1'b0;
        #1;
        chk("hold_rel_stall", 32'(stall_f), 32'd1);
        chk("hold_rel_flush", 32'(flush_e), 32'd1);
        step();
        chk("hold_rel_cnt", 32'(stall_cnt), 32'd2);
        chk("hold_rel_bubble", 32'(fwd_a_sel), 32'd0);
        step();
        chk("hold_rel_fwd_a", 32'(fwd_a_sel), 32'd3);
        chk("hold_rel_fwd_b", 32'(fwd_b_sel), 32'd3);
        idle(3);

        // Asynchronous reset with a load in stage 1
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
        step();
        drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
        #1;
        chk("rst_pre_stall", 32'(stall_f), 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_stall_f", 32'(stall_f), 32'd0);
        chk("rst_flush_e", 32'(flush_e), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_sat_cnt", 32'(s_stall_cnt), 32'd0);
        chk("rst_fwd_a", 32'(fwd_a_sel), 32'd0);
        #2;
        rst = 1'b1;
        idle(2);

        // Five load-use stalls: 16-bit counter reads 5, 2-bit counter saturates at 3
        repeat (5) begin
            drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
            step();
            drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
            step();
            step();
        end
        chk("sat_wide_cnt", 32'(stall_cnt), 32'd5);
        chk("sat_narrow_cnt", 32'(s_stall_cnt), 32'd3);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
